// File: rtl/sync_fifo_lvl_if.sv
// Handshake bundle for sync_fifo_lvl: write side, read side, level and error flags.
interface sync_fifo_lvl_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side that drives requests into the FIFO
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with arbitrary depth, FWFT or standard read mode,
// registered level thresholds, synchronous flush and sticky error flags.
module sync_fifo_lvl #(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 64,
  parameter int FWFT       = 1,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_lvl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic             full_nxt, empty_nxt, afull_nxt, aempty_nxt, ovf_nxt, unf_nxt;
  logic [WIDTH-1:0] rd_data_q, rd_data_nxt;
  logic             wr_acc, rd_acc;

  // Accept logic, pointer wrap, next count and next presented word
  always_comb begin
    wr_acc      = bus.wr_en & ~full_q & ~bus.flush;
    rd_acc      = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    count_nxt   = count_q;
    rd_data_nxt = rd_data_q;

    if (wr_acc)
      wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    if (rd_acc)
      rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase

    if (FWFT != 0) begin
      // The head after the edge is the slot being written right now when the
      // FIFO is (or becomes) otherwise empty, so bypass the RAM in that case.
      if (count_nxt != '0) begin
        if (wr_acc && (rd_ptr_nxt == wr_ptr))
          rd_data_nxt = bus.wr_data;
        else
          rd_data_nxt = mem[rd_ptr_nxt];
      end
    end else begin
      if (rd_acc)
        rd_data_nxt = mem[rd_ptr];
    end

    if (bus.flush) begin
      wr_ptr_nxt  = '0;
      rd_ptr_nxt  = '0;
      count_nxt   = '0;
      rd_data_nxt = '0;
    end
  end

  // Status flags derived from the next count, sticky errors from rejected requests
  always_comb begin
    full_nxt   = (count_nxt == CW'(DEPTH));
    empty_nxt  = (count_nxt == '0);
    afull_nxt  = (count_nxt >= CW'(AFULL_LVL));
    aempty_nxt = (count_nxt <= CW'(AEMPTY_LVL));
    ovf_nxt    = ovf_q | (bus.wr_en & full_q);
    unf_nxt    = unf_q | (bus.rd_en & empty_q);
    if (bus.flush) begin
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end
  end

  // Control state register with asynchronous clear of every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count_q   <= count_nxt;
      full_q    <= full_nxt;
      empty_q   <= empty_nxt;
      afull_q   <= afull_nxt;
      aempty_q  <= aempty_nxt;
      ovf_q     <= ovf_nxt;
      unf_q     <= unf_nxt;
      rd_data_q <= rd_data_nxt;
    end
  end

  // Storage RAM write port; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl: FWFT instance driven by a vector table
// and a queue scoreboard, plus a standard-mode instance for read latency.
module tb_sync_fifo_lvl;
  localparam int W = 8;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_lvl_if #(.WIDTH(W), .DEPTH(D)) bus_f ();
  sync_fifo_lvl_if #(.WIDTH(W), .DEPTH(D)) bus_s ();

  sync_fifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_LVL(4), .AEMPTY_LVL(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
  );
  sync_fifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_LVL(4), .AEMPTY_LVL(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic [2:0] cnt;
    logic       full;
    logic       afull;
    logic       aempty;
    logic       empty;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] q [$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic wr, input logic rd, input logic [7:0] d);
    bit acc_w, acc_r;
    @(negedge clk);
    bus_f.flush = fl;
    bus_f.wr_en = wr;
    bus_f.rd_en = rd;
    bus_f.wr_data = d;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wr && q.size() == D) m_ovf = 1'b1;
      if (rd && q.size() == 0) m_unf = 1'b1;
      acc_w = wr && (q.size() < D);
      acc_r = rd && (q.size() > 0);
      if (acc_r) void'(q.pop_front());
      if (acc_w) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStd(input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clk);
    bus_s.wr_en = wr;
    bus_s.rd_en = rd;
    bus_s.wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".count"}, 32'(bus_f.count), 32'(q.size()));
    checkOutput({tag, ".full"}, 32'(bus_f.full), 32'(q.size() == D));
    checkOutput({tag, ".empty"}, 32'(bus_f.empty), 32'(q.size() == 0));
    checkOutput({tag, ".afull"}, 32'(bus_f.almost_full), 32'(q.size() >= 4));
    checkOutput({tag, ".aempty"}, 32'(bus_f.almost_empty), 32'(q.size() <= 1));
    checkOutput({tag, ".overflow"}, 32'(bus_f.overflow), 32'(m_ovf));
    checkOutput({tag, ".underflow"}, 32'(bus_f.underflow), 32'(m_unf));
    if (q.size() > 0)
      checkOutput({tag, ".head"}, 32'(bus_f.rd_data), 32'(q[0]));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".full"}, 32'(bus_f.full), 0);
    checkOutput({tag, ".empty"}, 32'(bus_f.empty), 1);
    checkOutput({tag, ".afull"}, 32'(bus_f.almost_full), 0);
    checkOutput({tag, ".aempty"}, 32'(bus_f.almost_empty), 1);
    checkOutput({tag, ".count"}, 32'(bus_f.count), 0);
    checkOutput({tag, ".overflow"}, 32'(bus_f.overflow), 0);
    checkOutput({tag, ".underflow"}, 32'(bus_f.underflow), 0);
    checkOutput({tag, ".rd_data"}, 32'(bus_f.rd_data), 0);
    checkOutput({tag, ".std_empty"}, 32'(bus_s.empty), 1);
    checkOutput({tag, ".std_rd_data"}, 32'(bus_s.rd_data), 0);
  endtask

  // Main test sequence
  initial begin
    bus_f.flush = 0; bus_f.wr_en = 0; bus_f.rd_en = 0; bus_f.wr_data = 0;
    bus_s.flush = 0; bus_s.wr_en = 0; bus_s.rd_en = 0; bus_s.wr_data = 0;

    //              wr rd data   cnt full afull aempty empty
    vecs[0] = '{1'b1, 1'b0, 8'h10, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h12, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h13, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h14, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill/drain table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].data);
      checkOutput($sformatf("vec%0d.count", i), 32'(bus_f.count), 32'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d.full", i), 32'(bus_f.full), 32'(vecs[i].full));
      checkOutput($sformatf("vec%0d.afull", i), 32'(bus_f.almost_full), 32'(vecs[i].afull));
      checkOutput($sformatf("vec%0d.aempty", i), 32'(bus_f.almost_empty), 32'(vecs[i].aempty));
      checkOutput($sformatf("vec%0d.empty", i), 32'(bus_f.empty), 32'(vecs[i].empty));
      if (q.size() > 0)
        checkOutput($sformatf("vec%0d.head", i), 32'(bus_f.rd_data), 32'(q[0]));
    end

    $display("[TB] wrap-around with simultaneous read/write");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
      checkModel("preload");
    end
    for (int i = 0; i < 23; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(i));
      checkOutput($sformatf("wrap%0d.count3", i), 32'(bus_f.count), 3);
      checkModel($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkModel("wrapdrain");
    end

    $display("[TB] overflow and underflow");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
      checkModel("ofill");
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("ovf.set", 32'(bus_f.overflow), 1);
    checkOutput("ovf.count", 32'(bus_f.count), 5);
    checkModel("ovf");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkModel("odrain");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("unf.set", 32'(bus_f.underflow), 1);
    checkModel("unf");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkModel("sticky");
    end

    $display("[TB] flush with traffic");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
      checkModel("preflush");
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
    checkOutput("flush.count", 32'(bus_f.count), 0);
    checkOutput("flush.empty", 32'(bus_f.empty), 1);
    checkOutput("flush.overflow", 32'(bus_f.overflow), 0);
    checkOutput("flush.underflow", 32'(bus_f.underflow), 0);
    checkOutput("flush.rd_data", 32'(bus_f.rd_data), 0);
    checkModel("flush");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h42);
    checkOutput("postflush.head", 32'(bus_f.rd_data), 32'h42);
    checkModel("postflush");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkModel("postflush.pop");

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      checkModel("prereset");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("prereset.count4", 32'(bus_f.count), 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("asyncreset");
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkModel("afterreset");

    $display("[TB] standard read mode");
    applyStd(1'b1, 1'b0, 8'hA5);
    checkOutput("std.notempty", 32'(bus_s.empty), 0);
    checkOutput("std.count", 32'(bus_s.count), 1);
    checkOutput("std.notyet", 32'(bus_s.rd_data), 0);
    applyStd(1'b0, 1'b1, 8'h00);
    checkOutput("std.read", 32'(bus_s.rd_data), 32'hA5);
    checkOutput("std.empty", 32'(bus_s.empty), 1);
    for (int i = 0; i < 2; i++) begin
      applyStd(1'b0, 1'b0, 8'h00);
      checkOutput("std.hold", 32'(bus_s.rd_data), 32'hA5);
    end
    applyStd(1'b1, 1'b0, 8'h5A);
    checkOutput("std.holdwr", 32'(bus_s.rd_data), 32'hA5);
    applyStd(1'b0, 1'b1, 8'h00);
    checkOutput("std.read2", 32'(bus_s.rd_data), 32'h5A);
    applyStd(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Parametrised single-clock FIFO, the next generation of the coder's buffering FIFOs. It adds several things over the current blocks:
- arbitrary (non-power-of-two) depth;
- a selectable first-word-fall-through (FWFT) or standard read mode;
- a fill-level output with programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- sticky overflow and underflow error flags.

It sits between pixel/coefficient producers and the entropy coder stages, where back-pressure decisions use level thresholds rather than `full` alone.

## Interface
- `WIDTH`, 10, data word width in bits (≥1).
- `DEPTH`, 64, storage capacity in words (≥2, any integer).
- `FWFT`, 1, read mode:
  - 1: the head word is shown on `rd_data` whenever `empty` is 0.
  - 0: standard mode; data appears one cycle after the read.
- `AFULL_LVL`, DEPTH-2, `almost_full` asserts when count ≥ this value (1..DEPTH).
- `AEMPTY_LVL`, 2, `almost_empty` asserts when count ≤ this value (0..AFULL_LVL-1).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous clear of contents and sticky flags.
- `wr_en`  in  1  write request.
- `wr_data`  in  WIDTH  write word.
- `full`  out  1  no free slot.
- `almost_full`  out  1  count ≥ AFULL_LVL.
- `rd_en`  in  1  read/pop request.
- `rd_data`  out  WIDTH  read word.
- `empty`  out  1  no readable word.
- `almost_empty`  out  1  count ≤ AEMPTY_LVL.
- `count`  out  $clog2(DEPTH+1)  number of words held.
- `overflow`  out  1  sticky; a write was attempted while `full`.
- `underflow`  out  1  sticky; a read was attempted while `empty`.

## Operation
- A write is accepted iff `wr_en` & !`full`. A read is accepted iff `rd_en` & !`empty`.
  - `full` blocks writes even when a read is accepted in the same cycle.
- Storage is a DEPTH-entry RAM with write and read pointers.
  - Each pointer increments on its accepted access.
  - Each pointer wraps explicitly from DEPTH-1 to 0 (no power-of-two assumption).
- Count update per edge:
  - accepted write only: +1;
  - accepted read only: −1;
  - both accepted: unchanged;
  - neither: unchanged.
- `full`, `empty`, `almost_full` and `almost_empty` are registered and derived from the next value of `count`. They change on the same edge as `count`.
- In FWFT mode `count` includes the word currently presented on `rd_data`.
- `overflow` is set on the edge after any cycle with `wr_en` & `full`; `underflow` likewise for `rd_en` & `empty`.
  - Rejected requests change nothing else.
  - Both flags are cleared only by `flush` or reset.
- `flush`=1 at an edge:
  - pointers reset to 0; `count`=0; `empty`=1; `full`=0;
  - flags re-derived from count 0;
  - `overflow` and `underflow` cleared; `rd_data`=0;
  - `wr_en`/`rd_en` in that cycle are ignored, and no sticky flag is set by them.
- FWFT=1:
  - `rd_data` equals the oldest word whenever `empty`=0.
  - An accepted read presents the next-oldest word after the edge. `rd_data` is unchanged but stale if the FIFO becomes empty.
- FWFT=0:
  - `rd_data` updates on the edge following an accepted read.
  - It holds until the next accepted read.
- Reset values: `full`=0, `empty`=1, `almost_full`=0, `almost_empty`=1, `count`=0, `overflow`=0, `underflow`=0, `rd_data`=0.
  - Reset asserted mid-operation discards all contents immediately; the async action covers every output listed.

## Timing
- Write-to-visible latency is 1 cycle in both modes.
  - A write accepted at edge N into an empty FIFO gives `empty`=0 and `count`=1 after edge N.
  - In FWFT mode `rd_data` also shows the word after edge N.
- Read latency:
  - FWFT: 0 cycles (data valid while `rd_en` is sampled).
  - Standard: 1 cycle after the read edge.
- Sustained simultaneous read+write gives throughput of 1 word/cycle at any fill level 1..DEPTH-1, including across pointer wrap.
- Reading the last word while writing a new one in FWFT mode:
  - `empty` stays 0;
  - the new word appears on `rd_data` after the edge, with no bubble.
- No combinational path from `wr_en`/`rd_en` to any output.

## Test plan
- Reset and fill/drain:
  - Setup: WIDTH=8, DEPTH=5, FWFT=1, AFULL_LVL=4, AEMPTY_LVL=1.
  - Stimulus: write 0x10..0x14 on consecutive cycles.
  - Required: `count` goes 1..5; `almost_full` rises with count=4; `full` rises with count=5; `almost_empty` falls with count=2.
  - Then: pop 5 times. Required: `rd_data` reads 0x10..0x14 in order; `empty`=1 after the 5th pop.
- Wrap-around:
  - Setup: DEPTH=5.
  - Stimulus: 23 cycles of simultaneous write (0x00..0x16) and read after 3 pre-loaded words.
  - Required: `count` stays at 3; output sequence is exact and in order through multiple pointer wraps.
- Standard mode (FWFT=0):
  - Stimulus: write 0xA5, then assert `rd_en` one cycle.
  - Required: `rd_data`=0xA5 on the following cycle; the value holds until the next read.
- Error flags:
  - When full: `wr_en`=1 with 0xFF → `overflow`=1 next cycle; contents and `count`=5 unchanged.
  - When empty: `rd_en`=1 → `underflow`=1 next cycle.
  - Both flags stay set until `flush`.
- Flush with traffic:
  - Stimulus: `count`=3, `flush`=1 with `wr_en`=`rd_en`=1.
  - Required after the edge: `count`=0, `empty`=1, flags cleared, `rd_data`=0.
  - Then: write 0x42. Required: 0x42 is read first.
- Async reset mid-stream:
  - Stimulus: drop `rst_n` between edges while `count`=4.
  - Required: all outputs reach their reset values immediately, without a clock edge.
